// File: rtl/wind_sched_pkg.sv
// Shared constants and FSM encoding for the wind-vector converter scheduler.
// Defaults size the converter sharing for four channels of 16-bit data.
package wind_sched_pkg;

    localparam int NCH_D     = 4;
    localparam int CHW_D     = 2;
    localparam int INSIZE_D  = 16;
    localparam int BUSY_TO_D = 8;
    localparam int RUN_TO_D  = 64;
    localparam int TOW_D     = 7;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_WAITB = 3'd2,
        S_RUN   = 3'd3,
        S_DONE  = 3'd4
    } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first requester at or after the pointer.
// Returns the one-hot grant and its binary index.
module rr_arbiter
    import wind_sched_pkg::*;
#(
    parameter int NCH = NCH_D,
    parameter int CHW = CHW_D
) (
    input  logic [NCH-1:0] req,
    input  logic [CHW-1:0] ptr,
    output logic [NCH-1:0] grant,
    output logic [CHW-1:0] idx
);

    int   k;
    logic found;

    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        k     = 0;
        for (int j = 0; j < NCH; j++) begin
            k = int'(ptr) + j;
            if (k >= NCH) k = k - NCH;
            if (!found && req[k]) begin
                found    = 1'b1;
                grant[k] = 1'b1;
                idx      = CHW'(k);
            end
        end
    end

endmodule

// File: rtl/wind_conv_sched.sv
// Shares one rectangular-to-polar converter among NCH requesters,
// sequencing its start/busy handshake with timeouts and tagging results.
module wind_conv_sched
    import wind_sched_pkg::*;
#(
    parameter int NCH     = NCH_D,
    parameter int CHW     = CHW_D,
    parameter int INSIZE  = INSIZE_D,
    parameter int BUSY_TO = BUSY_TO_D,
    parameter int RUN_TO  = RUN_TO_D,
    parameter int TOW     = TOW_D
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [NCH-1:0]        req,
    input  logic [NCH*INSIZE-1:0] req_x,
    input  logic [NCH*INSIZE-1:0] req_y,
    output logic [NCH-1:0]        ack,
    output logic                  conv_start,
    output logic [INSIZE-1:0]     conv_x,
    output logic [INSIZE-1:0]     conv_y,
    input  logic                  conv_busy,
    input  logic [INSIZE-1:0]     conv_mod,
    input  logic [INSIZE-1:0]     conv_angle,
    output logic                  res_valid,
    output logic [CHW-1:0]        res_ch,
    output logic [INSIZE-1:0]     res_mod,
    output logic [INSIZE-1:0]     res_angle,
    output logic                  res_err,
    output logic                  sched_busy
);

    state_t         state, state_n;
    logic [CHW-1:0] ptr, gidx, cur_ch;
    logic [NCH-1:0] grant;
    logic [TOW-1:0] cnt;
    logic           do_grant, cnt_clr, cnt_inc, cap_ok, cap_err;

    rr_arbiter #(.NCH(NCH), .CHW(CHW)) u_arb (
        .req  (req),
        .ptr  (ptr),
        .grant(grant),
        .idx  (gidx)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= state_n;
    end

    always_comb begin
        state_n  = state;
        do_grant = 1'b0;
        cnt_clr  = 1'b0;
        cnt_inc  = 1'b0;
        cap_ok   = 1'b0;
        cap_err  = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (|req) begin
                    do_grant = 1'b1;
                    state_n  = S_START;
                end
            end
            S_START: begin
                cnt_clr = 1'b1;
                state_n = S_WAITB;
            end
            S_WAITB: begin
                if (conv_busy) begin
                    cnt_clr = 1'b1;
                    state_n = S_RUN;
                end else if (cnt == TOW'(BUSY_TO - 1)) begin
                    cap_err = 1'b1;
                    state_n = S_DONE;
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            S_RUN: begin
                if (!conv_busy) begin
                    cap_ok  = 1'b1;
                    state_n = S_DONE;
                end else if (cnt == TOW'(RUN_TO - 1)) begin
                    cap_err = 1'b1;
                    state_n = S_DONE;
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            S_DONE:  state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    // res_ch is taken from cur_ch at DONE so the previous result stays intact
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ack       <= '0;
            ptr       <= '0;
            cur_ch    <= '0;
            cnt       <= '0;
            conv_x    <= '0;
            conv_y    <= '0;
            res_ch    <= '0;
            res_mod   <= '0;
            res_angle <= '0;
            res_err   <= 1'b0;
        end else begin
            ack <= '0;
            if (do_grant) begin
                ack    <= grant;
                cur_ch <= gidx;
                conv_x <= req_x[gidx*INSIZE +: INSIZE];
                conv_y <= req_y[gidx*INSIZE +: INSIZE];
                ptr    <= (gidx == CHW'(NCH - 1)) ? '0 : gidx + 1'b1;
            end
            if (cnt_clr)      cnt <= '0;
            else if (cnt_inc) cnt <= cnt + 1'b1;
            if (cap_ok) begin
                res_ch    <= cur_ch;
                res_mod   <= conv_mod;
                res_angle <= conv_angle;
                res_err   <= 1'b0;
            end else if (cap_err) begin
                res_ch    <= cur_ch;
                res_mod   <= '0;
                res_angle <= '0;
                res_err   <= 1'b1;
            end
        end
    end

    assign conv_start = (state == S_START);
    assign res_valid  = (state == S_DONE);
    assign sched_busy = (state != S_IDLE);

endmodule

// File: tb/tb_wind_conv_sched.sv
// Directed bench for wind_conv_sched with a behavioural converter model.
// Converter model: busy rises the cycle after start and holds 20 cycles.
module tb_wind_conv_sched;

    logic        clock = 1'b0;
    logic        reset;
    logic [3:0]  req;
    logic [63:0] req_x, req_y;
    logic [3:0]  ack;
    logic        conv_start, conv_busy;
    logic [15:0] conv_x, conv_y, conv_mod, conv_angle;
    logic        res_valid, res_err, sched_busy;
    logic [1:0]  res_ch;
    logic [15:0] res_mod, res_angle;

    int errors = 0;
    int checks = 0;
    int mode   = 0;
    int bcnt;
    int nstarts = 0;
    int lat;
    logic [15:0] m_mod, m_ang;

    wind_conv_sched dut (
        .clock     (clock),
        .reset     (reset),
        .req       (req),
        .req_x     (req_x),
        .req_y     (req_y),
        .ack       (ack),
        .conv_start(conv_start),
        .conv_x    (conv_x),
        .conv_y    (conv_y),
        .conv_busy (conv_busy),
        .conv_mod  (conv_mod),
        .conv_angle(conv_angle),
        .res_valid (res_valid),
        .res_ch    (res_ch),
        .res_mod   (res_mod),
        .res_angle (res_angle),
        .res_err   (res_err),
        .sched_busy(sched_busy)
    );

    always #5 clock = ~clock;

    // mode 0: normal, 1: never busy, 2: busy stuck high
    always @(posedge clock or posedge reset) begin
        if (reset) begin
            bcnt  <= 0;
            m_mod <= '0;
            m_ang <= '0;
        end else if (conv_start) begin
            if (mode == 0) bcnt <= 20;
            if (conv_x == 16'd3 && conv_y == 16'd4) begin
                m_mod <= 16'd5;
                m_ang <= 16'd6801;
            end else begin
                m_mod <= conv_x + conv_y;
                m_ang <= conv_x - conv_y;
            end
        end else if (bcnt > 0) begin
            bcnt <= bcnt - 1;
        end
    end

    assign conv_busy  = (mode == 2) || (bcnt != 0);
    assign conv_mod   = m_mod;
    assign conv_angle = m_ang;

    always @(posedge clock) begin
        if (conv_start) nstarts <= nstarts + 1;
    end

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic serve(input int ch, input logic [3:0] drop,
                         input bit eerr, output int l);
        bit          got;
        int          s0;
        logic [15:0] ex, ey, em, ea;
        got = 0;
        l   = 0;
        for (int n = 0; n < 200 && !got; n++) begin
            @(negedge clock);
            if (ack != 4'b0) got = 1;
        end
        chk("ack_seen", 64'(got), 64'd1);
        if (!got) return;
        chk("ack_onehot", 64'(ack), 64'd1 << ch);
        chk("start_with_ack", 64'(conv_start), 64'd1);
        req = req & ~drop;
        s0  = nstarts;
        ex  = req_x[ch*16 +: 16];
        ey  = req_y[ch*16 +: 16];
        if (eerr) begin
            em = 16'd0;
            ea = 16'd0;
        end else if (ex == 16'd3 && ey == 16'd4) begin
            em = 16'd5;
            ea = 16'd6801;
        end else begin
            em = ex + ey;
            ea = ex - ey;
        end
        got = 0;
        for (int n = 1; n < 200 && !got; n++) begin
            @(negedge clock);
            if (conv_busy) begin
                chk("conv_x_hold", 64'(conv_x), 64'(ex));
                chk("conv_y_hold", 64'(conv_y), 64'(ey));
            end
            if (res_valid) begin
                got = 1;
                l   = n;
            end
        end
        chk("valid_seen", 64'(got), 64'd1);
        chk("res_ch", 64'(res_ch), 64'(ch));
        chk("res_err", 64'(res_err), 64'(eerr));
        chk("res_mod", 64'(res_mod), 64'(em));
        chk("res_angle", 64'(res_angle), 64'(ea));
        chk("one_start", 64'(nstarts), 64'(s0 + 1));
        @(negedge clock);
        chk("valid_pulse", 64'(res_valid), 64'd0);
        chk("back_idle", 64'(sched_busy), 64'd0);
    endtask

    initial begin
        reset = 1'b1;
        req   = 4'b0;
        for (int i = 0; i < 4; i++) begin
            req_x[i*16 +: 16] = 16'(100 * (i + 1));
            req_y[i*16 +: 16] = 16'(7 + 3 * i);
        end
        #3;
        chk("rst_ack", 64'(ack), 64'd0);
        chk("rst_start", 64'(conv_start), 64'd0);
        chk("rst_conv_x", 64'(conv_x), 64'd0);
        chk("rst_conv_y", 64'(conv_y), 64'd0);
        chk("rst_valid", 64'(res_valid), 64'd0);
        chk("rst_res", {res_mod, res_angle, 14'd0, res_ch}, 64'd0);
        chk("rst_err", 64'(res_err), 64'd0);
        chk("rst_busy", 64'(sched_busy), 64'd0);
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;

        // fairness: all four held, grants rotate 0,1,2,3,0
        req = 4'b1111;
        serve(0, 4'b0000, 1'b0, lat);
        serve(1, 4'b0000, 1'b0, lat);
        serve(2, 4'b0000, 1'b0, lat);
        serve(3, 4'b0000, 1'b0, lat);
        serve(0, 4'b1111, 1'b0, lat);

        // skip: pointer now 1, so channel 3 precedes channel 0
        req = 4'b1001;
        serve(3, 4'b1000, 1'b0, lat);
        serve(0, 4'b0001, 1'b0, lat);

        // single request with known converter answer
        req_x[15:0] = 16'd3;
        req_y[15:0] = 16'd4;
        req = 4'b0001;
        serve(0, 4'b0001, 1'b0, lat);

        // busy never rises
        mode = 1;
        req  = 4'b0100;
        serve(2, 4'b0100, 1'b1, lat);
        chk("busy_to_lat", 64'(lat), 64'd9);

        // busy stuck high
        mode = 2;
        req  = 4'b0010;
        serve(1, 4'b0010, 1'b1, lat);
        chk("run_to_lat", 64'(lat), 64'd66);

        mode = 0;
        req  = 4'b1000;
        serve(3, 4'b1000, 1'b0, lat);

        // reset in the middle of RUN
        req = 4'b0001;
        begin
            bit got;
            got = 0;
            for (int n = 0; n < 50 && !got; n++) begin
                @(negedge clock);
                if (ack != 4'b0) got = 1;
            end
            chk("rr_ack_seen", 64'(got), 64'd1);
        end
        req = 4'b0000;
        repeat (6) @(negedge clock);
        chk("mid_run_busy", 64'(sched_busy && conv_busy), 64'd1);
        reset = 1'b1;
        #1;
        chk("mr_ack", 64'(ack), 64'd0);
        chk("mr_start", 64'(conv_start), 64'd0);
        chk("mr_conv_x", 64'(conv_x), 64'd0);
        chk("mr_valid", 64'(res_valid), 64'd0);
        chk("mr_res", {res_mod, res_angle, 14'd0, res_ch}, 64'd0);
        chk("mr_busy", 64'(sched_busy), 64'd0);
        repeat (2) begin
            @(negedge clock);
            chk("mr_hold_valid", 64'(res_valid), 64'd0);
        end
        reset = 1'b0;
        req   = 4'b0010;
        serve(1, 4'b0010, 1'b0, lat);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
